// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter and sequencer for a single
// RAM port. One request is latched, driven to the RAM until ram_ready or a
// timeout, then reported with a one-cycle doneN pulse.
//
// Handshake: a requester raises reqN with we/addr/wdata and holds it until
// doneN. The request is taken on the IDLE edge where it is granted, and the
// fields are latched at that moment. Later changes to reqN or its fields are
// ignored until the access finishes. On the RAM side, ram_re/ram_we is held
// high until the first edge where ram_ready=1 is seen, or until the timeout
// expires. ram_rdata is only used on the edge where ram_ready=1.
module ram_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic              ram_ready,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Last counter value before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic              owner;     // requester that holds the RAM
    logic              prio;      // requester favoured on a tie
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              tmo_q;
    logic              any_req;
    logic              grant_sel;
    logic              tmo_hit;

    assign any_req = req0 | req1;
    // ram_ready has priority: timing out happens only on a cycle without it.
    assign tmo_hit = ~ram_ready && (cnt == CNT_LAST);

    // Pick the requester to grant: the only one asking, or prio on a tie.
    always_comb begin
        grant_sel = 1'b0;
        if (req0 && req1) begin
            grant_sel = prio;
        end else if (req1) begin
            grant_sel = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> ACCESS on any request, ACCESS -> DONE on
    // ready or timeout, DONE lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  if (ram_ready || tmo_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch the winning request, count wait cycles, and capture
    // the result and error flag. The tie priority moves on once per access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner   <= 1'b0;
            prio    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= grant_sel;
                        we_q    <= grant_sel ? we1 : we0;
                        addr_q  <= grant_sel ? addr1 : addr0;
                        wdata_q <= grant_sel ? wdata1 : wdata0;
                        cnt     <= '0;
                    end
                end
                ACCESS: begin
                    if (ram_ready) begin
                        if (!we_q) rdata_q <= ram_rdata;
                        tmo_q <= 1'b0;
                    end else if (tmo_hit) begin
                        rdata_q <= '0;
                        tmo_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    prio  <= ~owner;
                    tmo_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded only from registers, so they are free of input
    // paths and drop as soon as reset clears the state.
    assign busy        = (state != IDLE);
    assign gnt0        = busy && !owner;
    assign gnt1        = busy && owner;
    assign done0       = (state == DONE) && !owner;
    assign done1       = (state == DONE) && owner;
    assign ram_re      = (state == ACCESS) && !we_q;
    assign ram_we      = (state == ACCESS) && we_q;
    assign ram_addr    = (state == ACCESS) ? addr_q : '0;
    assign ram_wdata   = (state == ACCESS) ? wdata_q : '0;
    assign rdata       = rdata_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios followed by randomized
// two-requester traffic, with a RAM responder model and a completion
// scoreboard.
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1, timeout_err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_re, ram_we, ram_ready, busy;
    logic [DW-1:0] ram_rdata;

    // Clock generation.
    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .timeout_err(timeout_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_we(ram_we),
        .ram_ready(ram_ready), .ram_rdata(ram_rdata), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Expected completions per requester: {is_write, timed_out, read_data}.
    logic [DW+1:0] exp0_q[$];
    logic [DW+1:0] exp1_q[$];
    // Reference memory contents and the RAM model's own storage.
    logic [DW-1:0] model_mem[logic [AW-1:0]];
    logic [DW-1:0] ram_mem[logic [AW-1:0]];
    // What each requester has asked for: wait cycles and request fields.
    int            plan_wait[2];
    logic [AW-1:0] plan_addr[2];
    logic [DW-1:0] plan_wdata[2];
    logic          plan_we[2];
    int            grant_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
    endfunction

    // Strobe length: one cycle per wait cycle plus the ready cycle, capped
    // at the timeout length.
    function automatic int exp_len(input int w);
        return (w < TO) ? w + 1 : TO;
    endfunction

    task automatic preset(input logic [AW-1:0] a, input logic [DW-1:0] d);
        model_mem[a] = d;
        ram_mem[a]   = d;
    endtask

    task automatic drive(input int who, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (who == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // One complete transaction for one requester. It is called on a
    // negedge and returns on the negedge where done is seen.
    task automatic do_txn(input int who, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int wait_c,
                          input bit mid, input bit chk_lat);
        logic [DW-1:0] exp_rd;
        bit            tmo;
        int            n;
        int            m;
        tmo    = (wait_c >= TO);
        exp_rd = (tmo || w) ? '0 : model_rd(a);
        if (w && !tmo) model_mem[a] = d;
        plan_wait[who]  = wait_c;
        plan_addr[who]  = a;
        plan_wdata[who] = d;
        plan_we[who]    = w;
        if (who == 0) exp0_q.push_back({w, tmo, exp_rd});
        else          exp1_q.push_back({w, tmo, exp_rd});
        drive(who, 1'b1, w, a, d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(who == 1 ? gnt1 : gnt0) && n < 200);
        check(who == 1 ? "gnt1_seen" : "gnt0_seen", who == 1 ? gnt1 : gnt0, 1);
        if (n >= 200) return;
        if (mid) drive(who, 1'b0, ~w, 16'hFFFF, 16'($urandom));
        m = 0;
        while (!(who == 1 ? done1 : done0) && m < 300) begin
            @(negedge clk);
            m++;
        end
        check(who == 1 ? "done1_seen" : "done0_seen", who == 1 ? done1 : done0, 1);
        if (chk_lat) check("latency", n + m, exp_len(wait_c) + 1);
        drive(who, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rand_loop(input int who, input int count);
        int r;
        int w;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      w = $urandom_range(0, 3);
            else if (r < 9) w = $urandom_range(4, 7);
            else            w = 20;
            do_txn(who, 1'($urandom_range(0, 1)),
                   (who == 1 ? 16'h0100 : 16'h0030) + 16'($urandom_range(0, 7)),
                   16'($urandom), w, $urandom_range(0, 7) == 0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    // RAM responder: checks strobes against the owner's latched request,
    // raises ram_ready after the planned wait, and injects ram_ready noise
    // while no access is in progress.
    int            acc_cnt = 0;
    int            cur_plan = 0;
    logic          cur_who;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic          cur_we;
    always @(negedge clk) begin
        if (rst) begin
            acc_cnt   = 0;
            ram_ready = 1'b0;
            ram_rdata = '0;
        end else if (ram_re || ram_we) begin
            if (acc_cnt == 0) begin
                cur_who   = gnt1;
                cur_plan  = plan_wait[cur_who];
                cur_addr  = plan_addr[cur_who];
                cur_wdata = plan_wdata[cur_who];
                cur_we    = plan_we[cur_who];
                check("strobe_we", ram_we, cur_we);
            end
            check("ram_addr", ram_addr, cur_addr);
            if (cur_we) check("ram_wdata", ram_wdata, cur_wdata);
            if (acc_cnt == cur_plan) begin
                ram_ready = 1'b1;
                if (ram_we) ram_mem[ram_addr] = ram_wdata;
                else        ram_rdata = ram_rd(ram_addr);
            end else begin
                ram_ready = 1'b0;
                ram_rdata = 16'($urandom);
            end
            acc_cnt++;
        end else begin
            if (acc_cnt != 0) check("strobe_len", acc_cnt, exp_len(cur_plan));
            acc_cnt   = 0;
            ram_ready = 1'($urandom_range(0, 1));
            ram_rdata = 16'($urandom);
        end
    end

    // Completion monitor: pops the scoreboard on each done pulse and checks
    // the structural invariants every cycle.
    logic [DW-1:0] exp_last = '0;
    logic          prev_done0 = 1'b0, prev_done1 = 1'b0;
    logic          prev_gnt0 = 1'b0, prev_gnt1 = 1'b0;
    logic [DW+1:0] e;
    logic [DW-1:0] exp_rd_m;
    always @(negedge clk) begin
        if (rst) begin
            exp_last   = '0;
            prev_done0 = 1'b0; prev_done1 = 1'b0;
            prev_gnt0  = 1'b0; prev_gnt1  = 1'b0;
        end else begin
            check("gnt_excl", gnt0 & gnt1, 0);
            check("strobe_excl", ram_re & ram_we, 0);
            check("busy_gnt", busy, gnt0 | gnt1);
            if (gnt0 && !prev_gnt0) grant_log.push_back(0);
            if (gnt1 && !prev_gnt1) grant_log.push_back(1);
            if (done0 || done1) begin
                check("done_width", done0 ? prev_done0 : prev_done1, 0);
                check("done_gnt", done0 ? gnt0 : gnt1, 1);
                check("done_strobes", {ram_re, ram_we, ram_addr}, 0);
                if ((done0 ? exp0_q.size() : exp1_q.size()) == 0) begin
                    check("spurious_done", done0 | done1, 0);
                end else begin
                    e = done0 ? exp0_q.pop_front() : exp1_q.pop_front();
                    exp_rd_m = e[DW] ? '0 : (e[DW+1] ? exp_last : e[DW-1:0]);
                    check("rdata", rdata, exp_rd_m);
                    check("timeout_err", timeout_err, e[DW]);
                    exp_last = exp_rd_m;
                end
            end else begin
                check("tmo_idle", timeout_err, 0);
            end
            prev_done0 = done0; prev_done1 = done1;
            prev_gnt0  = gnt0;  prev_gnt1  = gnt1;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    // Main sequence.
    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        ram_ready = 1'b0;
        ram_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", {gnt1, gnt0}, 0);
        check("rst_done", {done1, done0}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_strobes", {ram_re, ram_we}, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Both requesters held high from reset: grants alternate from 0.
        grant_log.delete();
        fork
            begin
                do_txn(0, 1'b0, 16'h0030, '0, 0, 1'b0, 1'b0);
                do_txn(0, 1'b0, 16'h0031, '0, 2, 1'b0, 1'b0);
            end
            begin
                do_txn(1, 1'b0, 16'h0101, '0, 1, 1'b0, 1'b0);
                do_txn(1, 1'b0, 16'h0102, '0, 0, 1'b0, 1'b0);
            end
        join
        check("contention_cnt", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("contention_order", grant_log[i], i % 2);
        @(negedge clk);

        // Zero-wait read.
        preset(16'h0032, 16'hBEEF);
        do_txn(0, 1'b0, 16'h0032, '0, 0, 1'b0, 1'b1);
        check("read_beef", rdata, 16'hBEEF);
        @(negedge clk);

        // Write with wait states leaves rdata alone.
        do_txn(1, 1'b1, 16'h0100, 16'h1234, 3, 1'b0, 1'b1);
        check("write_keeps_rdata", rdata, 16'hBEEF);
        check("write_committed", ram_mem[16'h0100], 16'h1234);
        @(negedge clk);

        // Timeout on a read, then a normal access.
        do_txn(0, 1'b0, 16'h0040, '0, 20, 1'b0, 1'b1);
        check("timeout_rdata", rdata, 0);
        @(negedge clk);
        do_txn(0, 1'b0, 16'h0032, '0, 1, 1'b0, 1'b1);
        check("after_timeout", rdata, 16'hBEEF);
        @(negedge clk);

        // Inputs changed and req dropped mid-access.
        do_txn(0, 1'b0, 16'h0033, '0, 2, 1'b1, 1'b1);
        @(negedge clk);

        // Asynchronous reset in the middle of an access.
        plan_wait[0] = 50; plan_addr[0] = 16'h0034; plan_we[0] = 1'b0; plan_wdata[0] = '0;
        drive(0, 1'b1, 1'b0, 16'h0034, '0);
        for (int i = 0; i < 20 && !gnt0; i++) @(negedge clk);
        @(negedge clk);
        check("pre_rst_re", ram_re, 1);
        #2 rst = 1'b1;
        #1;
        check("async_re", ram_re, 0);
        check("async_gnt0", gnt0, 0);
        check("async_busy", busy, 0);
        drive(0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        grant_log.delete();
        fork
            do_txn(0, 1'b0, 16'h0035, '0, 0, 1'b0, 1'b0);
            do_txn(1, 1'b0, 16'h0103, '0, 0, 1'b0, 1'b0);
        join
        check("post_rst_first", grant_log.size() > 0 ? grant_log[0] : 9, 0);
        @(negedge clk);

        // Randomized concurrent traffic.
        fork
            rand_loop(0, 40);
            rand_loop(1, 40);
        join
        repeat (4) @(negedge clk);
        check("exp0_empty", exp0_q.size(), 0);
        check("exp1_empty", exp1_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
